// File: rtl/gate_sweep_checker.sv
// Purpose: sweeps a two-input gate bank through its truth table for ROUNDS rounds and checks all seven outputs.
// Latency: 2 cycles per vector (settle + compare), 8*ROUNDS busy cycles, then a one-cycle done pulse.
// Backpressure: none; start is only sampled in IDLE and is never queued. Optional macro: GATE_SWEEP_INJECT_EN.
module gate_sweep_checker #(
  parameter int ROUNDS = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef GATE_SWEEP_INJECT_EN
  input  logic             inj_err,
`endif
  input  logic             p,
  input  logic             q,
  input  logic             r,
  input  logic             s,
  input  logic             t,
  input  logic             c,
  input  logic             d,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [6:0]       err_mask,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST_RND = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [RW-1:0]    rnd_q, rnd_d;
  logic [6:0]       err_mask_q, err_mask_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic             pass_q, pass_d;
  logic             a_q, a_d;
  logic             b_q, b_d;

  logic [6:0]       exp_bits;
  logic [6:0]       obs_bits;
  logic [6:0]       mis_bits;
  logic             any_mis;
  logic             last_vec;

  // Expected gate outputs for the currently driven vector, optionally corrupted on bit 0 for self-test
  always_comb begin
    exp_bits = {~a_q, ~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), a_q | b_q, ~(a_q & b_q), a_q & b_q};
`ifdef GATE_SWEEP_INJECT_EN
    exp_bits[0] = exp_bits[0] ^ inj_err;
`endif
    obs_bits = {d, c, t, s, r, q, p};
    mis_bits = obs_bits ^ exp_bits;
    any_mis  = |mis_bits;
    last_vec = (idx_q == 2'd3) && (rnd_q == LAST_RND);
  end

  // State register; reset wins over any pending start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DRIVE and SAMPLE alternate until the last vector of the last round
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_DRIVE;
      S_DRIVE:  state_d = S_SAMPLE;
      S_SAMPLE: state_d = last_vec ? S_DONE : S_DRIVE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state
  always_comb begin
    busy = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    done = (state_q == S_DONE);
  end

  // Datapath next-state: run setup, per-vector scoring with saturating counters, verdict on the final compare
  always_comb begin
    idx_d      = idx_q;
    rnd_d      = rnd_q;
    err_mask_d = err_mask_q;
    err_cnt_d  = err_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    pass_d     = pass_q;
    a_d        = a_q;
    b_d        = b_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d      = 2'd0;
          rnd_d      = '0;
          err_mask_d = '0;
          err_cnt_d  = '0;
          vec_cnt_d  = '0;
          pass_d     = 1'b0;
          a_d        = 1'b0;
          b_d        = 1'b0;
        end
      end
      S_SAMPLE: begin
        err_mask_d = err_mask_q | mis_bits;
        if (any_mis && (err_cnt_q != {CNT_W{1'b1}})) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (vec_cnt_q != {CNT_W{1'b1}}) begin
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
        end
        idx_d      = idx_q + 2'd1;
        {a_d, b_d} = idx_q + 2'd1;
        if (last_vec) begin
          // Verdict is registered on entry to DONE so it is already valid during the done pulse
          pass_d = (err_cnt_q == '0) && !any_mis;
        end else if (idx_q == 2'd3) begin
          rnd_d = rnd_q + RW'(1);
        end
      end
      S_DONE: begin
        a_d = 1'b0;
        b_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; synchronous reset clears every visible result
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= 2'd0;
      rnd_q      <= '0;
      err_mask_q <= '0;
      err_cnt_q  <= '0;
      vec_cnt_q  <= '0;
      pass_q     <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      rnd_q      <= rnd_d;
      err_mask_q <= err_mask_d;
      err_cnt_q  <= err_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      pass_q     <= pass_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign pass     = pass_q;
  assign err_mask = err_mask_q;
  assign err_cnt  = err_cnt_q;
  assign vec_cnt  = vec_cnt_q;

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking test stage wrapped around the two-input gate bank (AND, NAND, OR, NOR, XOR, XNOR, NOT). It drives the bank's `a`/`b` inputs through the full truth table for a programmable number of rounds and consumes the seven gate outputs. It compares each output against the expected value and reports per-gate sticky error flags, counters and a pass/fail verdict. It sits directly around the gate bank in the bring-up and regression harness.

## Interface
Parameters:
- `ROUNDS`, 4: number of complete 4-vector truth-table sweeps per run (≥1).
- `CNT_W`, 8: width of the vector and error counters.

Ports:
- `clk`  in  1  the only clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `a_out`  out  1  drives gate bank input `a`.
- `b_out`  out  1  drives gate bank input `b`.
- `p`, `q`, `r`, `s`, `t`, `c`, `d`  in  1 each  gate bank outputs: AND, NAND, OR, NOR, XOR, XNOR, NOT(a).
- `busy`  out  1  high in DRIVE and SAMPLE.
- `done`  out  1  single-cycle pulse at the end of a run.
- `pass`  out  1  high when the last completed run had zero mismatches; held until the next accepted start.
- `err_mask`  out  7  sticky per-gate mismatch flags, bit order {d,c,t,s,r,q,p} (bit 0 = p).
- `err_cnt`  out  CNT_W  number of vectors with ≥1 mismatching bit; saturating.
- `vec_cnt`  out  CNT_W  number of vectors sampled; saturating.

## Operation
- FSM states: IDLE → DRIVE → SAMPLE → (DRIVE | DONE) → IDLE.
- IDLE: `start`=1 is accepted. On that edge `err_mask`, `err_cnt`, `vec_cnt`, `pass`, the vector index `idx` (2 bits) and the round counter are cleared, {`a_out`,`b_out`} is set to 2'b00, and the state goes to DRIVE.
- DRIVE: vector {`a_out`,`b_out`}=`idx` is held for one settle cycle, then the state goes to SAMPLE.
- SAMPLE: the inputs {d,c,t,s,r,q,p} are compared against exp = {~a, ~(a^b), a^b, ~(a|b), a|b, ~(a&b), a&b}, using the registered `a_out`/`b_out`.
  - `err_mask` |= mismatch bits.
  - `err_cnt` +1 if any mismatch.
  - `vec_cnt` +1.
  - `idx` increments and wraps 3→0, and {`a_out`,`b_out`} is updated to the new `idx` on the same edge.
- Exit from SAMPLE: if `idx`=3 and the round counter = ROUNDS-1, go to DONE; otherwise the round counter increments on wrap and the state goes to DRIVE.
- DONE: `done`=1 for exactly one cycle and `pass` <= (`err_cnt`==0 and no mismatch on the final vector). The state then returns to IDLE. `a_out`/`b_out` return to 0.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `start` in DRIVE, SAMPLE or DONE is ignored and is not queued.
- `rst`=1 in any state, including mid-run, gives IDLE with every output 0 on the next edge.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_mask`=0, `err_cnt`=0, `vec_cnt`=0.
- `rst` has priority over `start` on the same edge.
- Each vector takes 2 cycles. A run occupies 8·ROUNDS busy cycles.
- Run timeline, with `start` accepted at edge 0:
  - `busy` is high during cycles 1 … 8·ROUNDS.
  - `done` is high in cycle 8·ROUNDS+1. For ROUNDS=4 this is cycle 33.
  - A new `start` is accepted from cycle 8·ROUNDS+2.
- Counters and `err_mask` update on the edge that ends each SAMPLE cycle.
- `pass` is valid from the `done` cycle onward.
- The gate bank is combinational. A settle of one cycle (DRIVE) precedes every compare.

## Configuration
- `GATE_SWEEP_INJECT_EN` defined: adds input port `inj_err` (1 bit).
  - While `inj_err`=1 during SAMPLE, expected bit 0 (p) is inverted. This forces a mismatch on a correct bank and is used for checker self-test.
- `GATE_SWEEP_INJECT_EN` undefined: the port is absent and the expected value is always the true function.

## Test plan
- Correct gate bank, ROUNDS=4, pulse `start`:
  - `done` pulses in cycle 33.
  - `pass`=1, `err_cnt`=0, `vec_cnt`=16, `err_mask`=7'b0000000.
- `r` stuck-at-0, ROUNDS=4:
  - Mismatch on vectors 01, 10 and 11 of every round.
  - `err_cnt`=12, `vec_cnt`=16, `err_mask`=7'b0000100, `pass`=0.
- `rst` asserted in cycle 10 of a run:
  - Next cycle: IDLE, all outputs 0, no `done`.
  - A fresh `start` then completes cleanly with `pass`=1 at cycle 33.
- `start` held high for 40 cycles:
  - Exactly one run, with `done` in cycle 33.
  - A second run is accepted at cycle 34.
- CNT_W=3, ROUNDS=4, `q` inverted on every vector:
  - `err_cnt`=7 and `vec_cnt`=7 (both saturated).
  - `err_mask`=7'b0000010, `pass`=0.
- With `GATE_SWEEP_INJECT_EN` defined, correct bank, `inj_err`=1 for the whole run:
  - `err_mask`=7'b0000001, `err_cnt`=16, `pass`=0.
